// File: rtl/dmem_arbiter_if.sv
// Bundles the two requester ports and the memory-side bus of the data-memory
// arbiter. The slave modport is the arbiter's view. The master modport is the
// view seen by the surrounding requesters and the memory.
`timescale 1ns/1ps
interface dmem_arbiter_if;
    // port 0: CPU load/store
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        err0;
    // port 1: debug / program loader
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;
    logic [31:0] rdata1;
    logic        err1;
    // single-port memory
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    // status
    logic        busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_dout,
        output ack0, rdata0, err0,
        output ack1, rdata1, err1,
        output mem_we, mem_addr, mem_din,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_dout,
        input  ack0, rdata0, err0,
        input  ack1, rdata1, err1,
        input  mem_we, mem_addr, mem_din,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port byte-addressed data memory.
// Each transaction takes three cycles: IDLE (arbitrate and latch the command),
// ACCESS (drive memory for one cycle), and RESP (one-cycle ack with the result).
// An access that is out of range or misaligned is flagged as an error and never
// writes memory.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES   = 64,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    dmem_arbiter_if.slave bus
);

    // Highest legal word start address. The compare against it is unsigned 32-bit.
    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg;
    logic        id_reg;          // port that owns the transaction in flight
    logic        err_reg;         // the latched command is illegal
    logic        last_grant_reg;  // most recent winner, used for round-robin
    logic [1:0]  ack_reg;
    logic [1:0]  err_out_reg;
    logic [31:0] rdata_out_reg [2];
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;    // also acts as the latched command address
    logic [31:0] mem_din_reg;     // also acts as the latched command write data
    logic        busy_reg;

    // Per-port views of the request inputs, indexed by port number.
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [31:0] addr_vec  [2];
    logic [31:0] wdata_vec [2];

    assign req_vec      = {bus.req1, bus.req0};
    assign we_vec       = {bus.we1, bus.we0};
    assign addr_vec[0]  = bus.addr0;
    assign addr_vec[1]  = bus.addr1;
    assign wdata_vec[0] = bus.wdata0;
    assign wdata_vec[1] = bus.wdata1;

    logic        win_next;
    logic        win_we_next;
    logic [31:0] win_addr_next;
    logic [31:0] win_wdata_next;
    logic        win_err_next;

    // Choose the winner among the current requests and classify its address.
    always_comb begin
        win_next = req_vec[1];
        if (&req_vec) begin
            // On a tie, either port 0 always wins or the port that was not
            // granted last time wins.
            win_next = FIXED_PRIO ? 1'b0 : ~last_grant_reg;
        end
        win_we_next    = we_vec[win_next];
        win_addr_next  = addr_vec[win_next];
        win_wdata_next = wdata_vec[win_next];
        win_err_next   = (win_addr_next > LAST_WORD_ADDR) ||
                         (ALIGN_CHECK && (win_addr_next[1:0] != 2'b00));
    end

    // Transaction sequencer. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            id_reg           <= 1'b0;
            err_reg          <= 1'b0;
            last_grant_reg   <= 1'b1;
            ack_reg          <= 2'b00;
            err_out_reg      <= 2'b00;
            rdata_out_reg[0] <= 32'h0;
            rdata_out_reg[1] <= 32'h0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= 32'h0;
            mem_din_reg      <= 32'h0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        id_reg         <= win_next;
                        err_reg        <= win_err_next;
                        last_grant_reg <= win_next;
                        mem_addr_reg   <= win_addr_next;
                        mem_din_reg    <= win_wdata_next;
                        mem_we_reg     <= win_we_next & ~win_err_next;
                        busy_reg       <= 1'b1;
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write commits on this edge. The read data is captured
                    // for writes as well, and an error forces it to zero.
                    mem_we_reg             <= 1'b0;
                    ack_reg[id_reg]        <= 1'b1;
                    err_out_reg[id_reg]    <= err_reg;
                    rdata_out_reg[id_reg]  <= err_reg ? 32'h0 : bus.mem_dout;
                    state_reg              <= RESP;
                end
                RESP: begin
                    ack_reg          <= 2'b00;
                    err_out_reg      <= 2'b00;
                    rdata_out_reg[0] <= 32'h0;
                    rdata_out_reg[1] <= 32'h0;
                    busy_reg         <= 1'b0;
                    state_reg        <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = ack_reg[0];
    assign bus.ack1     = ack_reg[1];
    assign bus.err0     = err_out_reg[0];
    assign bus.err1     = err_out_reg[1];
    assign bus.rdata0   = rdata_out_reg[0];
    assign bus.rdata1   = rdata_out_reg[1];
    assign bus.mem_we   = mem_we_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_din  = mem_din_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. It builds three instances: default (round-robin,
// alignment checked), fixed priority, and alignment check off. Each instance
// has its own byte memory. Requests come from per-port command queues, and
// the expected grant order, error flags, read data and memory contents come
// from a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_d   [3][2];
    logic        we_d    [3][2];
    logic [31:0] addr_d  [3][2];
    logic [31:0] wdata_d [3][2];
    logic        ack_o   [3][2];
    logic        err_o   [3][2];
    logic [31:0] rdata_o [3][2];
    logic        mem_we_o   [3];
    logic        busy_o     [3];
    logic [31:0] mem_addr_o [3];
    logic [31:0] mem_din_o  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        dmem_arbiter_if bus();
        logic [7:0] mem [64] = '{default: 8'h00};

        dmem_arbiter #(
            .MEM_BYTES  (64),
            .ALIGN_CHECK(gi != 2),
            .FIXED_PRIO (gi == 1)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave)
        );

        assign bus.req0   = req_d[gi][0];
        assign bus.we0    = we_d[gi][0];
        assign bus.addr0  = addr_d[gi][0];
        assign bus.wdata0 = wdata_d[gi][0];
        assign bus.req1   = req_d[gi][1];
        assign bus.we1    = we_d[gi][1];
        assign bus.addr1  = addr_d[gi][1];
        assign bus.wdata1 = wdata_d[gi][1];
        assign ack_o[gi][0]   = bus.ack0;
        assign ack_o[gi][1]   = bus.ack1;
        assign err_o[gi][0]   = bus.err0;
        assign err_o[gi][1]   = bus.err1;
        assign rdata_o[gi][0] = bus.rdata0;
        assign rdata_o[gi][1] = bus.rdata1;
        assign mem_we_o[gi]   = bus.mem_we;
        assign busy_o[gi]     = bus.busy;
        assign mem_addr_o[gi] = bus.mem_addr;
        assign mem_din_o[gi]  = bus.mem_din;

        // Little-endian byte memory with a combinational read and a write on the clock edge.
        assign bus.mem_dout = {mem[6'(bus.mem_addr + 32'd3)], mem[6'(bus.mem_addr + 32'd2)],
                               mem[6'(bus.mem_addr + 32'd1)], mem[bus.mem_addr[5:0]]};
        always @(posedge clk) begin
            if (bus.mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    mem[6'(bus.mem_addr + 32'(i))] <= bus.mem_din[8*i +: 8];
                end
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t       q [2][$];
    logic [7:0] ref_mem  [3][64];
    logic       ref_last [3];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.we   = we;
        c.addr = a;
        c.data = d;
        q[p].push_back(c);
    endtask

    // An access is illegal when it starts past the last word or is misaligned.
    // Instance 2 does not check alignment.
    function automatic logic exp_err(input int k, input logic [31:0] a);
        return (a > 32'd60) || ((k != 2) && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] ref_read(input int k, input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[k][6'(a + 32'(i))];
        return v;
    endfunction

    // The next port served: a lone requester wins. On a tie, instance 1 favours
    // port 0, and the others favour the port not served last.
    function automatic int pick(input int k);
        if (q[0].size() != 0 && q[1].size() != 0) begin
            if (k == 1) return 0;
            return ref_last[k] ? 0 : 1;
        end
        return (q[0].size() != 0) ? 0 : 1;
    endfunction

    task automatic present(input int k);
        for (int p = 0; p < 2; p++) begin
            req_d[k][p] = (q[p].size() != 0);
            if (q[p].size() != 0) begin
                we_d[k][p]    = q[p][0].we;
                addr_d[k][p]  = q[p][0].addr;
                wdata_d[k][p] = q[p][0].data;
            end
        end
    endtask

    // Serve both queues on instance k, starting at a negedge in IDLE. A port
    // with more commands presents the next one in its ack cycle.
    task automatic run(input int k);
        int          w;
        cmd_t        c;
        logic        e;
        logic [31:0] rd;
        present(k);
        while (q[0].size() != 0 || q[1].size() != 0) begin
            w  = pick(k);
            c  = q[w][0];
            e  = exp_err(k, c.addr);
            rd = e ? 32'h0 : ref_read(k, c.addr);
            tick();
            chk("access_mem_we", 32'(mem_we_o[k]), 32'(c.we & ~e));
            chk("access_mem_addr", mem_addr_o[k], c.addr);
            chk("access_mem_din", mem_din_o[k], c.data);
            chk("access_no_ack", {30'h0, ack_o[k][1], ack_o[k][0]}, 32'h0);
            chk("access_busy", 32'(busy_o[k]), 32'h1);
            tick();
            chk("resp_ack_winner", 32'(ack_o[k][w]), 32'h1);
            chk("resp_ack_other", 32'(ack_o[k][1-w]), 32'h0);
            chk("resp_err", 32'(err_o[k][w]), 32'(e));
            chk("resp_rdata", rdata_o[k][w], rd);
            chk("resp_other_err", 32'(err_o[k][1-w]), 32'h0);
            chk("resp_other_rdata", rdata_o[k][1-w], 32'h0);
            chk("resp_mem_we", 32'(mem_we_o[k]), 32'h0);
            $display("dut%0d port%0d %s addr=%08h wdata=%08h err=%0d rdata=%08h",
                     k, w, c.we ? "WR" : "RD", c.addr, c.data, err_o[k][w], rdata_o[k][w]);
            if (c.we && !e) begin
                for (int i = 0; i < 4; i++) ref_mem[k][6'(c.addr + 32'(i))] = c.data[8*i +: 8];
            end
            ref_last[k] = (w == 1);
            void'(q[w].pop_front());
            present(k);
            tick();
            chk("idle_no_ack", {30'h0, ack_o[k][1], ack_o[k][0]}, 32'h0);
            chk("idle_busy", 32'(busy_o[k]), 32'h0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        if (sel < 8) return 32'($urandom_range(0, 70));
        if (sel == 8) return 32'hFFFF_FFFC;
        return $urandom;
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ref_last[k] = 1'b1;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = 8'h00;
            for (int p = 0; p < 2; p++) begin
                req_d[k][p]   = 1'b1;
                we_d[k][p]    = 1'b0;
                addr_d[k][p]  = 32'h0;
                wdata_d[k][p] = 32'h0;
            end
        end

        // Reset held with both requests high: everything stays quiet.
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack0", 32'(ack_o[k][0]), 32'h0);
            chk("rst_ack1", 32'(ack_o[k][1]), 32'h0);
            chk("rst_err0", 32'(err_o[k][0]), 32'h0);
            chk("rst_err1", 32'(err_o[k][1]), 32'h0);
            chk("rst_rdata0", rdata_o[k][0], 32'h0);
            chk("rst_rdata1", rdata_o[k][1], 32'h0);
            chk("rst_mem_we", 32'(mem_we_o[k]), 32'h0);
            chk("rst_mem_addr", mem_addr_o[k], 32'h0);
            chk("rst_mem_din", mem_din_o[k], 32'h0);
            chk("rst_busy", 32'(busy_o[k]), 32'h0);
        end
        for (int k = 1; k < 3; k++) begin
            req_d[k][0] = 1'b0;
            req_d[k][1] = 1'b0;
        end
        // Release with both ports of instance 0 requesting: port 0 goes first.
        push(0, 1'b0, 32'h0, 32'h0);
        push(1, 1'b0, 32'h4, 32'h0);
        rst_n = 1'b1;
        run(0);

        // Write, then read back.
        push(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
        push(0, 1'b0, 32'h8, 32'h0);
        run(0);

        // Sustained contention: the ports alternate.
        push(0, 1'b1, 32'h20, 32'h1111_0000);
        push(0, 1'b0, 32'h20, 32'h0);
        push(1, 1'b1, 32'h24, 32'h2222_0000);
        push(1, 1'b0, 32'h24, 32'h0);
        run(0);

        // Out-of-range and misaligned accesses on port 1, then the affected word.
        push(1, 1'b1, 32'h3E, 32'hFFFF_FFFF);
        push(1, 1'b1, 32'h5, 32'hFFFF_FFFF);
        push(1, 1'b0, 32'h3C, 32'h0);
        push(1, 1'b0, 32'h4, 32'h0);
        run(0);
        // With alignment checking off, byte address 5 is a legal access.
        push(0, 1'b1, 32'h5, 32'hA5A5_1234);
        push(0, 1'b0, 32'h5, 32'h0);
        push(0, 1'b0, 32'h4, 32'h0);
        push(0, 1'b0, 32'h3D, 32'h0);
        run(2);

        // Reset during the access cycle of a write aborts it.
        push(0, 1'b1, 32'h10, 32'hCAFE_F00D);
        run(0);
        req_d[0][0]   = 1'b1;
        we_d[0][0]    = 1'b1;
        addr_d[0][0]  = 32'h10;
        wdata_d[0][0] = 32'h1234_5678;
        tick();
        chk("abort_mem_we_before", 32'(mem_we_o[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_we_async", 32'(mem_we_o[0]), 32'h0);
        chk("abort_busy_async", 32'(busy_o[0]), 32'h0);
        req_d[0][0] = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) ref_last[k] = 1'b1;
        repeat (2) begin
            tick();
            chk("abort_no_ack", {30'h0, ack_o[0][1], ack_o[0][0]}, 32'h0);
        end
        push(0, 1'b0, 32'h10, 32'h0);
        run(0);

        // Fixed priority: port 1 waits until port 0 has nothing left.
        push(0, 1'b1, 32'h0, 32'h0A0A_0A0A);
        push(0, 1'b1, 32'h4, 32'h0B0B_0B0B);
        push(0, 1'b0, 32'h0, 32'h0);
        push(1, 1'b0, 32'h4, 32'h0);
        run(1);

        // Random traffic on all three instances.
        for (int r = 0; r < 45; r++) begin
            int k;
            k = r % 3;
            for (int p = 0; p < 2; p++) begin
                int n;
                n = int'($urandom_range(0, 3));
                for (int j = 0; j < n; j++) push(p, 1'($urandom), rand_addr(), $urandom);
            end
            if (q[0].size() == 0 && q[1].size() == 0) push(1, 1'b0, rand_addr(), 32'h0);
            run(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
